branch_sequencer: RTL and testbench

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_sequencer_pkg.sv | 14 +
 rtl/branch_sequencer.sv | 114 +++++++++++
 tb/tb_branch_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_pkg.sv
// Shared constants and state type for the Bicc/JMPL fetch sequencer.
package branch_sequencer_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    ANNUL = 1'b1
  } state_e;

  localparam logic [3:0]  COND_BA    = 4'b1000;
  localparam logic [3:0]  COND_BN    = 4'b0000;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/branch_sequencer.sv
// SPARC-style pc/npc sequencer with Bicc annul handling and JMPL redirect.
// Optional statistics counters are enabled by defining BR_STATS_EN.
module branch_sequencer
  import branch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [3:0]  br_cond,
  input  logic        br_annul,
  input  logic [21:0] br_disp,
  input  logic [31:0] id_pc,
  input  logic        jmpl_valid,
  input  logic [31:0] jmpl_target,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        annul_ds,
  output logic        misalign,
  output logic [31:0] br_taken_cnt,
  output logic [31:0] br_annul_cnt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic        misalign_q, misalign_d;

  logic [31:0] br_target;
  logic [31:0] jmpl_aligned;
  logic        run_go;
  logic        take_jmpl;
  logic        take_br;
  logic        annul_req;
  logic        enter_annul;

  assign br_target    = id_pc + {{8{br_disp[21]}}, br_disp, 2'b00};
  assign jmpl_aligned = {jmpl_target[31:2], 2'b00};

  // Decode inputs only count in RUN without stall; JMPL outranks a same-cycle Bicc.
  assign run_go      = (state_q == RUN) && !stall;
  assign take_jmpl   = run_go && jmpl_valid;
  assign take_br     = run_go && br_valid && !jmpl_valid;
  assign annul_req   = br_annul && (br_taken ? (br_cond == COND_BA) : 1'b1);
  assign enter_annul = take_br && annul_req;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    misalign_d = take_jmpl && (jmpl_target[1:0] != 2'b00);
    if (!stall) begin
      pc_d    = npc_q;
      npc_d   = npc_q + WORD_BYTES;
      state_d = RUN;
      if (take_jmpl) begin
        pc_d  = jmpl_aligned;
        npc_d = jmpl_aligned + WORD_BYTES;
      end else if (take_br && br_taken) begin
        pc_d  = br_target;
        npc_d = br_target + WORD_BYTES;
      end
      if (enter_annul) begin
        state_d = ANNUL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      npc_q      <= RESET_PC + WORD_BYTES;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc       = pc_q;
  assign npc      = npc_q;
  assign annul_ds = (state_q == ANNUL);
  assign misalign = misalign_q;

`ifdef BR_STATS_EN
  logic [31:0] taken_cnt_q;
  logic [31:0] annul_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_cnt_q <= '0;
      annul_cnt_q <= '0;
    end else begin
      if (take_br && br_taken) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end
      if (enter_annul) begin
        annul_cnt_q <= annul_cnt_q + 32'd1;
      end
    end
  end

  assign br_taken_cnt = taken_cnt_q;
  assign br_annul_cnt = annul_cnt_q;
`else
  assign br_taken_cnt = '0;
  assign br_annul_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios plus random traffic vs a behavioural model.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic [3:0]  br_cond;
  logic        br_annul;
  logic [21:0] br_disp;
  logic [31:0] id_pc;
  logic        jmpl_valid;
  logic [31:0] jmpl_target;
  logic [31:0] pc, npc, br_taken_cnt, br_annul_cnt;
  logic        annul_ds, misalign;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference state
  logic [31:0] m_pc, m_npc, m_tcnt, m_acnt;
  bit          m_squash, m_mis;

  branch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .br_valid(br_valid), .br_taken(br_taken), .br_cond(br_cond),
    .br_annul(br_annul), .br_disp(br_disp), .id_pc(id_pc),
    .jmpl_valid(jmpl_valid), .jmpl_target(jmpl_target),
    .pc(pc), .npc(npc), .annul_ds(annul_ds), .misalign(misalign),
    .br_taken_cnt(br_taken_cnt), .br_annul_cnt(br_annul_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] stat(input logic [31:0] n);
`ifdef BR_STATS_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: applies the architectural rules once per edge.
  always @(posedge clk) begin
    int signed   d;
    logic [31:0] tgt;
    bit          mis_next;
    mis_next = 0;
    if (!rst_n) begin
      m_pc = 0; m_npc = 4; m_squash = 0; m_tcnt = 0; m_acnt = 0;
    end else if (!stall) begin
      if (m_squash) begin
        m_pc = m_npc; m_npc = m_npc + 4; m_squash = 0;
      end else if (jmpl_valid) begin
        tgt = jmpl_target - (jmpl_target % 4);
        m_pc = tgt; m_npc = tgt + 4;
        mis_next = (jmpl_target % 4) != 0;
      end else if (br_valid) begin
        d = $signed(br_disp);
        tgt = id_pc + 32'(d * 4);
        if (br_taken) begin
          m_pc = tgt; m_npc = tgt + 4; m_tcnt = m_tcnt + 1;
        end else begin
          m_pc = m_npc; m_npc = m_npc + 4;
        end
        if ((br_taken && br_annul && br_cond == 4'd8) || (!br_taken && br_annul)) begin
          m_squash = 1; m_acnt = m_acnt + 1;
        end
      end else begin
        m_pc = m_npc; m_npc = m_npc + 4;
      end
    end
    if (rst_n) m_mis = mis_next; else m_mis = 0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc", pc, m_pc);
      check("model_npc", npc, m_npc);
      check("model_annul_ds", {31'd0, annul_ds}, {31'd0, m_squash});
      check("model_misalign", {31'd0, misalign}, {31'd0, m_mis});
      check("model_taken_cnt", br_taken_cnt, stat(m_tcnt));
      check("model_annul_cnt", br_annul_cnt, stat(m_acnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br_valid = 0; br_taken = 0; br_cond = 4'd0; br_annul = 0; br_disp = '0;
    id_pc = '0; jmpl_valid = 0; jmpl_target = '0; stall = 0;
  endtask

  task automatic bicc(input logic [31:0] ipc, input logic [21:0] disp, input logic tk,
                      input logic [3:0] cond, input logic a);
    br_valid = 1; id_pc = ipc; br_disp = disp; br_taken = tk; br_cond = cond; br_annul = a;
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick(); tick();
    chk_en = 1;
    check("reset_pc", pc, 32'h0);
    check("reset_npc", npc, 32'h4);
    check("reset_annul", {31'd0, annul_ds}, 32'd0);
    check("reset_misalign", {31'd0, misalign}, 32'd0);
    check("reset_cnt", br_taken_cnt | br_annul_cnt, 32'd0);

    // Sequential fetch after reset
    rst_n = 1;
    tick(); check("seq_pc1", pc, 32'h4);
    tick(); check("seq_pc2", pc, 32'h8);
    tick(); check("seq_pc3", pc, 32'hC);
    check("seq_annul", {31'd0, annul_ds}, 32'd0);

    // Taken conditional, a=0
    bicc(32'h100, 22'h10, 1, 4'b1001, 0);
    tick();
    check("bcc_pc", pc, 32'h140);
    check("bcc_npc", npc, 32'h144);
    check("bcc_annul", {31'd0, annul_ds}, 32'd0);

    // BA,a: annul for one cycle; a branch offered in the delay slot is ignored
    bicc(32'h200, 22'h10, 1, 4'b1000, 1);
    tick();
    check("ba_a_pc", pc, 32'h240);
    check("ba_a_annul", {31'd0, annul_ds}, 32'd1);
    bicc(32'h900, 22'h40, 1, 4'b1001, 0);
    tick();
    check("ba_a_ignored_pc", pc, 32'h244);
    check("ba_a_annul_drop", {31'd0, annul_ds}, 32'd0);
    check("ba_a_annul_cnt", br_annul_cnt, stat(32'd1));

    // Not-taken with a=1, then two stall cycles
    bicc(32'h244, 22'h8, 0, 4'b1001, 1);
    tick();
    check("nt_a_pc", pc, 32'h248);
    check("nt_a_annul", {31'd0, annul_ds}, 32'd1);
    idle(); stall = 1;
    tick(); check("nt_stall1_annul", {31'd0, annul_ds}, 32'd1);
    check("nt_stall1_pc", pc, 32'h248);
    tick(); check("nt_stall2_annul", {31'd0, annul_ds}, 32'd1);
    check("nt_stall2_npc", npc, 32'h24C);
    stall = 0;
    tick(); check("nt_release_annul", {31'd0, annul_ds}, 32'd0);
    check("nt_release_pc", pc, 32'h24C);

    // JMPL misaligned with a competing BA,a
    bicc(32'h500, 22'h4, 1, 4'b1000, 1);
    jmpl_valid = 1; jmpl_target = 32'h303;
    tick();
    check("jmpl_pc", pc, 32'h300);
    check("jmpl_npc", npc, 32'h304);
    check("jmpl_misalign", {31'd0, misalign}, 32'd1);
    check("jmpl_no_annul", {31'd0, annul_ds}, 32'd0);
    idle();
    tick();
    check("jmpl_misalign_drop", {31'd0, misalign}, 32'd0);
    check("jmpl_next_pc", pc, 32'h304);
    check("cnt_taken", br_taken_cnt, stat(32'd2));
    check("cnt_annul", br_annul_cnt, stat(32'd2));

    // npc wraps at 2^32
    jmpl_valid = 1; jmpl_target = 32'hFFFF_FFFC;
    tick();
    check("wrap_npc", npc, 32'h0);
    idle();
    tick();
    check("wrap_pc", pc, 32'h0);

    // Negative displacement
    bicc(32'h100, 22'h3F_FFFF, 1, 4'b1001, 0);
    tick();
    check("negdisp_pc", pc, 32'hFC);
    idle();

    // Reset while annulling under stall
    bicc(32'h100, 22'h4, 0, 4'b0000, 1);
    tick();
    check("pre_rst_annul", {31'd0, annul_ds}, 32'd1);
    idle(); stall = 1; rst_n = 0;
    tick();
    check("rst_annul_pc", pc, 32'h0);
    check("rst_annul_npc", npc, 32'h4);
    check("rst_annul_ds", {31'd0, annul_ds}, 32'd0);
    check("rst_annul_cnt", br_taken_cnt | br_annul_cnt, 32'd0);
    rst_n = 1; stall = 0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      br_valid    = ($urandom_range(0, 9) < 3);
      br_taken    = $urandom_range(0, 1) == 1;
      br_cond     = ($urandom_range(0, 2) == 0) ? 4'b1000 : 4'($urandom);
      br_annul    = $urandom_range(0, 1) == 1;
      br_disp     = 22'($urandom);
      id_pc       = $urandom;
      jmpl_valid  = ($urandom_range(0, 9) == 0);
      jmpl_target = $urandom;
      tick();
    end

    idle();
    tick();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
